// File: rtl/test_din_arb.sv
// test_din_arb: per-channel input FIFOs feeding one registered output,
// served by a round-robin arbiter with valid/ready handshakes on both sides.
module test_din_arb #(
  parameter int DWIDTH   = 16,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          din_valid,
  output logic [CHANNELS-1:0]          din_ready,
  input  logic [CHANNELS*DWIDTH-1:0]   din_data,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [DWIDTH-1:0]            dout_data,
  output logic [CW-1:0]                dout_chan
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [SW-1:0] NCH = SW'(CHANNELS);
  localparam logic [CW-1:0] LAST_RST = CW'(CHANNELS - 1);

  logic [DWIDTH-1:0]   mem   [CHANNELS][DEPTH];
  logic [PW-1:0]       wptr  [CHANNELS];
  logic [PW-1:0]       rptr  [CHANNELS];
  logic [PW:0]         count [CHANNELS];
  logic [CW-1:0]       last_grant;
  logic [CW-1:0]       grant;
  logic [CHANNELS-1:0] nonempty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic                load;

  // Ready and occupancy derive only from registered counts.
  always_comb begin
    nonempty  = '0;
    din_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      nonempty[i]  = (count[i] != '0);
      din_ready[i] = (count[i] != FULL);
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    logic [SW-1:0] idx;
    logic          found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = SW'(last_grant) + SW'(i + 1);
      if (idx >= NCH)
        idx = idx - NCH;
      if (!found && nonempty[idx[CW-1:0]]) begin
        found = 1'b1;
        grant = idx[CW-1:0];
      end
    end
  end

  // Output register refills whenever it is free or being drained.
  always_comb begin
    load = (!dout_valid || dout_ready) && (|nonempty);
    push = din_valid & din_ready;
    pop  = '0;
    if (load)
      pop[grant] = 1'b1;
  end

  // Storage array; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i])
        mem[i][wptr[i]] <= din_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Per-channel pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (push[i])
          wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])
          rptr[i] <= rptr[i] + PW'(1);
        unique case (1'b1)
          push[i] && !pop[i]: count[i] <= count[i] + (PW+1)'(1);
          pop[i] && !push[i]: count[i] <= count[i] - (PW+1)'(1);
          default:            count[i] <= count[i];
        endcase
      end
    end
  end

  // Output register and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_chan  <= '0;
      last_grant <= LAST_RST;
    end else if (load) begin
      dout_valid <= 1'b1;
      dout_data  <= mem[grant][rptr[grant]];
      dout_chan  <= grant;
      last_grant <= grant;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_test_din_arb.sv
// tb_test_din_arb: random and directed traffic against a queue-based
// reference model; a scoreboard checks every accepted output word.
module tb_test_din_arb;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int DP = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            chan;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [NC-1:0]    din_valid;
  logic [NC-1:0]    din_ready;
  logic [NC*DW-1:0] din_data;
  logic             dout_valid;
  logic             dout_ready;
  logic [DW-1:0]    dout_data;
  logic [1:0]       dout_chan;

  test_din_arb #(.DWIDTH(DW), .CHANNELS(NC), .DEPTH(DP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .din_data(din_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data(dout_data),
    .dout_chan(dout_chan)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sq [NC][$];
  logic [DW-1:0] mq [NC][$];
  exp_t          sb [$];
  bit            m_valid = 0;
  int            m_last = NC - 1;

  logic [NC-1:0] rdy_s = '0;
  bit            gap_en = 0;
  int            rmode = 0;
  bit            ready_val = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queues per channel, output slot, round-robin pointer.
  initial begin
    logic [NC-1:0] acc;
    int g;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NC; i++) mq[i].delete();
        sb.delete();
        m_valid = 0;
        m_last = NC - 1;
      end else begin
        for (int i = 0; i < NC; i++)
          acc[i] = din_valid[i] && (mq[i].size() < DP);
        if (!m_valid || dout_ready) begin
          g = -1;
          for (int k = 1; k <= NC; k++)
            if (g < 0 && mq[(m_last + k) % NC].size() > 0)
              g = (m_last + k) % NC;
          if (g >= 0) begin
            exp_t e;
            e.data = mq[g].pop_front();
            e.chan = g;
            sb.push_back(e);
            m_last = g;
            m_valid = 1;
          end else begin
            m_valid = 0;
          end
        end
        for (int i = 0; i < NC; i++)
          if (acc[i]) mq[i].push_back(din_data[i*DW +: DW]);
      end
    end
  end

  // Monitor: compares flow control each cycle and words on handshake.
  initial begin
    logic [NC-1:0] m_ready;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < NC; i++)
          m_ready[i] = (mq[i].size() != DP);
        chk("din_ready", 32'(din_ready), 32'(m_ready));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        if (dout_valid && dout_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", dout_data);
          end else begin
            e = sb.pop_front();
            chk("dout_data", 32'(dout_data), 32'(e.data));
            chk("dout_chan", 32'(dout_chan), 32'(e.chan));
          end
        end
      end
    end
  end

  // Ready snapshot for the driver, taken away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      rdy_s = rst_n ? din_ready : '0;
    end
  end

  // Driver: offers queued words, retires them on handshake.
  initial begin
    din_valid  = '0;
    din_data   = '0;
    dout_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++) begin
        if (rst_n && din_valid[i] && rdy_s[i] && sq[i].size() > 0)
          void'(sq[i].pop_front());
        din_valid[i] = (sq[i].size() > 0) &&
                       !(gap_en && ($urandom % 3 == 0));
        din_data[i*DW +: DW] = (sq[i].size() > 0) ? sq[i][0] : '0;
      end
      case (rmode)
        1:       dout_ready = ~dout_ready;
        2:       dout_ready = 1'($urandom % 2);
        default: dout_ready = ready_val;
      endcase
    end
  end

  function automatic bit sq_empty();
    for (int i = 0; i < NC; i++)
      if (sq[i].size() != 0) return 0;
    return 1;
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < NC; i++)
      if (mq[i].size() != 0) return 0;
    return sb.size() == 0 && !m_valid;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!sq_empty() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!sq_empty()) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got pending words expected none");
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rmode = 0;
    ready_val = 1;
    while (!(sq_empty() && model_idle()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!(sq_empty() && model_idle() && !dout_valid)) begin
      errors++;
      $display("FAIL drain: got busy expected idle");
    end
  endtask

  initial begin
    rst_n = 1;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_din_ready", 32'(din_ready), 32'hF);
    chk("rst_dout_data", 32'(dout_data), 0);
    chk("rst_dout_chan", 32'(dout_chan), 0);
    @(negedge clk);
    rst_n = 1;

    // Single word on channel 2.
    ready_val = 1;
    sq[2].push_back(16'h1234);
    wait_idle(20);
    drain(50);

    // All channels busy: rotating grants at full rate.
    for (int i = 0; i < NC; i++)
      for (int k = 0; k < 8; k++)
        sq[i].push_back(16'($urandom));
    wait_idle(100);
    drain(100);

    // Backpressure until channel 0 fills.
    ready_val = 0;
    for (int k = 1; k <= 6; k++)
      sq[0].push_back(16'(k));
    repeat (10) @(negedge clk);
    chk("bp_ready0", 32'(din_ready[0]), 0);
    chk("bp_pending", 32'(sq[0].size()), 1);
    chk("bp_head", 32'(dout_data), 32'h1);
    drain(100);

    // Pointer wrap with toggling downstream ready.
    for (int k = 0; k < 32; k++)
      sq[1].push_back(16'(k));
    rmode = 1;
    wait_idle(200);
    drain(200);

    // Reset in the middle of buffered traffic.
    ready_val = 0;
    for (int k = 0; k < 4; k++)
      sq[3].push_back(16'(16'hA0 + k));
    wait_idle(50);
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 32'(dout_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_ready", 32'(din_ready), 32'hF);
    #1 rst_n = 1;
    ready_val = 1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", 32'(dout_valid), 0);

    // Skip empty channels: grant history on channel 0 first.
    sq[0].push_back(16'h0C00);
    wait_idle(20);
    drain(50);
    sq[0].push_back(16'h0C01);
    sq[0].push_back(16'h0C02);
    sq[3].push_back(16'h3C01);
    sq[3].push_back(16'h3C02);
    wait_idle(50);
    drain(50);

    // Random traffic with random gaps and backpressure.
    gap_en = 1;
    rmode = 2;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++)
        if (sq[i].size() < 3 && $urandom % 2 == 1)
          sq[i].push_back(16'($urandom));
    end
    gap_en = 0;
    wait_idle(500);
    drain(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test_din_arb.md
TEST_DIN_ARB -- requirements
Module: test_din_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (1..16).
REQ-003 SHALL have parameter DEPTH, default 4, per-channel FIFO entries (power of 2, >=2).
REQ-004 SHALL define local CW = max(1, clog2(CHANNELS)).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port din_valid  input  CHANNELS  per-channel word offered.
REQ-008 SHALL have port din_ready  output  CHANNELS  per-channel FIFO can accept.
REQ-009 SHALL have port din_data  input  CHANNELS*DWIDTH  flattened; channel i at bits [i*DWIDTH +: DWIDTH].
REQ-010 SHALL have port dout_valid  output  1  output register holds a word.
REQ-011 SHALL have port dout_ready  input  1  downstream accepts.
REQ-012 SHALL have port dout_data  output  DWIDTH  output word.
REQ-013 SHALL have port dout_chan  output  CW  source channel of dout_data.

Function
REQ-014 SHALL keep one DEPTH-entry FIFO per channel with count 0..DEPTH.
REQ-015 SHALL drive din_ready[i] = (count[i] != DEPTH), from registered state only, no combinational path from din_valid.
REQ-016 SHALL push din_data[i] into FIFO i on an edge where din_valid[i] && din_ready[i].
REQ-017 SHALL load the output register when (!dout_valid || dout_ready) and at least one FIFO is non-empty at that cycle's start, popping the granted FIFO on the same edge.
REQ-018 SHALL clear dout_valid when dout_valid && dout_ready and no FIFO is non-empty.
REQ-019 SHALL hold dout_valid, dout_data, dout_chan stable while dout_valid && !dout_ready.
REQ-020 SHALL grant round-robin: search starts at (last_grant+1) mod CHANNELS; first non-empty channel wins; last_grant updates only on a pop.
REQ-021 SHALL reset last_grant to CHANNELS-1 so channel 0 has first priority.
REQ-022 SHALL give latency: word pushed to empty FIFO at edge k appears with dout_valid=1 after edge k+1 if the output register is free.
REQ-023 SHALL sustain one word per clock at dout with dout_ready held high while any FIFO is non-empty.
REQ-024 SHALL on simultaneous push and pop of the same channel keep count unchanged and preserve FIFO order.
REQ-025 SHALL wrap read/write pointers modulo DEPTH without loss or duplication.
REQ-026 SHALL, when full, keep din_ready low until the edge after a pop; no overwrite.
REQ-027 SHALL preserve per-channel order at dout; inter-channel order follows REQ-020.
REQ-028 SHALL with CHANNELS=1 drive dout_chan=0 and operate as a single FIFO plus output register.

Reset
REQ-029 SHALL on rst_n low, asynchronously: all counts and pointers 0, last_grant=CHANNELS-1, dout_valid=0, dout_data=0, dout_chan=0, din_ready all ones.
REQ-030 SHALL discard all buffered words on reset mid-operation; no word accepted before reset appears afterwards.
REQ-031 SHALL ignore din_valid while rst_n is low.

Verification
REQ-032 Single word: DWIDTH=16, CHANNELS=4, DEPTH=4; ch2 drives 0x1234 one cycle, dout_ready=1 -> dout_valid=1, dout_data=0x1234, dout_chan=2 after edge k+1, one cycle only.
REQ-033 Fairness: all four channels valid continuously, dout_ready=1 -> dout_chan sequence 0,1,2,3,0,1,... and one word per clock.
REQ-034 Backpressure/full: ch0 pushes 0x0001..0x0006, dout_ready=0 -> din_ready[0] low after 4 FIFO words + 1 held in output (5 accepted); release -> dout 0x0001..0x0005 in order, 0x0006 then accepted.
REQ-035 Wrap-around: ch1 streams 0x0000..0x001F with dout_ready toggling every cycle -> all 32 words out in order, no gaps or repeats.
REQ-036 Reset mid-stream: ch3 FIFO holding 3 words, dout_valid=1, pulse rst_n low between edges -> dout_valid=0 immediately, din_ready=4'hF, none of the 3 words appear after release.
REQ-037 Skip empty: only ch0 and ch3 valid, last grant 0 -> next grant ch3, then ch0.
